gpr_commit_trace: RTL
=====================

# gpr_commit_trace

Parametrised commit-trace unit for the NPC core's difftest and debug infrastructure. It keeps a clocked shadow copy of the general-purpose register file, updated only by retired instructions, and a circular history of the last DEPTH commits (pc, rd, wen, wdata). The history can be frozen on a trap and read back by age through a registered request/ack port. It sits beside the writeback stage and is driven only by the commit bus, never by speculative state.

## Interface
- XLEN, 64, register and data width
- NREGS, 32, number of architectural registers (power of two, ≥2)
- DEPTH, 16, history entries (power of two, ≥2)
- PCW, 64, pc width
- AW = $clog2(NREGS), HW = $clog2(DEPTH) (derived localparams)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  PCW  pc of retiring instruction
- commit_wen  in  1  instruction writes a register
- commit_rd  in  AW  destination register index
- commit_wdata  in  XLEN  writeback value
- freeze_req  in  1  pulse: stop recording history
- unfreeze_req  in  1  pulse: resume recording
- frozen  out  1  history recording stopped
- count  out  HW+1  valid history entries, 0..DEPTH
- commit_cnt  out  64  total commits since reset
- sh_addr  in  AW  shadow read index
- sh_data  out  XLEN  shadow register value (combinational read of registered state)
- rd_req  in  1  history read request
- rd_age  in  HW  0 = newest entry
- rd_ack  out  1  response valid, one cycle
- rd_hit  out  1  rd_age < count at request time
- rd_pc / rd_rd / rd_wen / rd_data  out  PCW / AW / 1 / XLEN  entry fields

## Operation
- Shadow regfile: written when commit_valid && commit_wen && commit_rd != 0. Writes to x0 are dropped and sh_data is 0 for sh_addr 0. Shadow updates regardless of frozen.
- commit_cnt increments on every commit_valid, wraps at 2^64, ignores frozen.
- History ring: wptr (HW bits) and count.
  - Each commit_valid while !frozen writes {pc, rd, wen, data} at wptr. When wen=0, the stored rd and data are forced to 0.
  - wptr increments modulo DEPTH. count saturates at DEPTH; once full, the oldest entry is overwritten.
- Freeze FSM has two states, RUN and FROZEN.
  - RUN→FROZEN on freeze_req. FROZEN→RUN on unfreeze_req.
  - If both are asserted in one cycle, freeze wins.
  - A commit in the same cycle as freeze_req is still recorded. Freezing takes effect from the next cycle.
- Readout: rd_req samples rd_age against the pre-edge count and wptr.
  - Entry index = (wptr − 1 − rd_age) mod DEPTH.
  - On a hit, the response presents the entry fields. On a miss (rd_age ≥ count), rd_hit=0 and all fields are 0.
  - A commit in the same cycle as rd_req does not affect that response.
  - Readout works in both RUN and FROZEN.

## Timing
- Reset values: frozen=0, count=0, commit_cnt=0, rd_ack=0, rd_hit=0, rd_* fields=0, all shadow regs=0, wptr=0. History contents need no reset, because count gates hits.
- Shadow write visible on sh_data the cycle after commit.
- count and commit_cnt update at the commit edge.
- frozen rises the cycle after freeze_req.
- rd_ack asserts exactly one cycle after rd_req, for one cycle. Back-to-back requests give back-to-back acks.
- Reset asserted mid-operation immediately clears all outputs, including an in-flight ack.

## Test plan
- Reset, then 3 commits (pc 0x80000000/4/8; rd 1/2/0; data 0x11/0x22/0x33; all wen=1) -> sh_data(1)=0x11, sh_data(2)=0x22, sh_data(0)=0; count=3; commit_cnt=3. Read age 2 -> hit, pc 0x80000000, rd 1, data 0x11.
- 20 commits with DEPTH=16 (pc = 0x100+4i) -> count=16. Read age 0 -> pc 0x14C. Read age 15 -> pc 0x110. Read age 16 is impossible (HW=4); repeat with DEPTH=32 and age 25 -> rd_hit=0, fields 0.
- freeze_req together with a commit (pc 0x200), then 5 more commits -> history newest pc 0x200, count unchanged after freeze, shadow and commit_cnt still advance. Then unfreeze_req; next commit recorded.
- freeze_req and unfreeze_req in the same cycle -> frozen=1.
- Commit with wen=0, rd=5, data 0xFF -> shadow x5 unchanged; history entry has rd=0, wen=0, data=0.
- rd_req in the same cycle as a commit, age 0 -> returns the prior newest entry. Reset asserted during ack -> rd_ack drops immediately, count=0.

Source files
------------

// File: rtl/gpr_commit_trace.sv
// Commit-trace unit: shadow GPR file, commit counter and a freezable circular
// history of the last DEPTH retired instructions with a registered age-indexed readout.
module gpr_commit_trace #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int DEPTH = 16,
    parameter int PCW   = 64,
    localparam int AW   = $clog2(NREGS),
    localparam int HW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [PCW-1:0]  commit_pc,
    input  logic            commit_wen,
    input  logic [AW-1:0]   commit_rd,
    input  logic [XLEN-1:0] commit_wdata,
    input  logic            freeze_req,
    input  logic            unfreeze_req,
    output logic            frozen,
    output logic [HW:0]     count,
    output logic [63:0]     commit_cnt,
    input  logic [AW-1:0]   sh_addr,
    output logic [XLEN-1:0] sh_data,
    input  logic            rd_req,
    input  logic [HW-1:0]   rd_age,
    output logic            rd_ack,
    output logic            rd_hit,
    output logic [PCW-1:0]  rd_pc,
    output logic [AW-1:0]   rd_rd,
    output logic            rd_wen,
    output logic [XLEN-1:0] rd_data
);

    typedef enum logic {RUN, FROZEN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] shadow [NREGS];
    logic [PCW-1:0]  hist_pc   [DEPTH];
    logic [AW-1:0]   hist_rd   [DEPTH];
    logic            hist_wen  [DEPTH];
    logic [XLEN-1:0] hist_data [DEPTH];
    logic [HW-1:0]   wptr;
    logic [HW-1:0]   rd_idx;
    logic            rd_in_range;
    logic            record;
    logic            sh_we;

    // Freeze FSM: a simultaneous freeze and unfreeze resolves to frozen.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: the default is assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            RUN:     if (freeze_req) state_d = FROZEN;
            FROZEN:  if (unfreeze_req && !freeze_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign frozen = (state_q == FROZEN);
    assign record = commit_valid && !frozen;
    assign sh_we  = commit_valid && commit_wen && (commit_rd != '0);

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the shadow file is architecturally visible after reset, so it is reset; history is not.
        if (reset) begin
            for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
        end else if (sh_we) begin
            shadow[commit_rd] <= commit_wdata;
        end
    end

    assign sh_data = (sh_addr == '0) ? '0 : shadow[sh_addr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_cnt <= '0;
            wptr       <= '0;
            count      <= '0;
        end else begin
            if (commit_valid) commit_cnt <= commit_cnt + 64'd1;
            if (record) begin
                wptr <= wptr + HW'(1);
                if (count != (HW+1)'(DEPTH)) count <= count + (HW+1)'(1);
            end
        end
    end

    // History payload is only ever observed through count, so it carries no reset.
    always_ff @(posedge clock) begin
        if (record) begin
            hist_pc[wptr]   <= commit_pc;
            hist_wen[wptr]  <= commit_wen;
            hist_rd[wptr]   <= commit_wen ? commit_rd : '0;
            hist_data[wptr] <= commit_wen ? commit_wdata : '0;
        end
    end

    assign rd_idx      = wptr - HW'(1) - rd_age;
    assign rd_in_range = ({1'b0, rd_age} < count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ack  <= 1'b0;
            rd_hit  <= 1'b0;
            rd_pc   <= '0;
            rd_rd   <= '0;
            rd_wen  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_req;
            rd_hit <= rd_req && rd_in_range;
            if (rd_req && rd_in_range) begin
                rd_pc   <= hist_pc[rd_idx];
                rd_rd   <= hist_rd[rd_idx];
                rd_wen  <= hist_wen[rd_idx];
                rd_data <= hist_data[rd_idx];
            end else begin
                rd_pc   <= '0;
                rd_rd   <= '0;
                rd_wen  <= 1'b0;
                rd_data <= '0;
            end
        end
    end

endmodule
